// File: rtl/pll_reset_pkg.sv
// Shared state type, retry-counter width and counter sizing helper for the PLL reset sequencer.
package pll_reset_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } pll_rst_state_t;

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_bit_sync.sv
// N-stage flip-flop synchroniser (STAGES >= 2) with synchronous active-high clear.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, qualifies the synchronised lock and holds sys_rst until lock is stable.
// Optional feature: define PLL_AUTO_RELOCK_EN to re-pulse the PLL (and count a retry) when lock drops in RUN.
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int LOCK_SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int HOLD_CYCLES         = 256
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retries,
    output logic               lost_lock
);

    localparam int MAX_A   = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
    localparam int MAX_B   = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = cntWidth(MAX_CNT);

    // The lock sample that moves WAIT_LOCK into STABLE is already the first stable cycle, hence the -2.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    pll_rst_state_t     state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RETRY_W-1:0] retries_q;
    logic [RETRY_W-1:0] retries_d;
    logic               pllRst_q;
    logic               sysRst_q;
    logic               ready_q;
    logic               lostLock_q;
    logic               relPend_q;
    logic               lockS;

    bit_sync #(
        .STAGES (LOCK_SYNC_STAGES)
    ) u_lockSync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (lockS)
    );

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = (retries_q == '1) ? retries_q : retries_q + RETRY_W'(1);
    end

    // relPend_q keeps the reset values for one extra edge so the first pll_rst pulse
    // ends PLL_RST_CYCLES edges after the first edge that samples rst low.
    always_ff @(posedge refclk) begin
        lostLock_q <= 1'b0;
        if (rst || relPend_q) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pllRst_q  <= 1'b1;
            sysRst_q  <= 1'b1;
            ready_q   <= 1'b0;
            relPend_q <= rst;
            if (rst) begin
                retries_q <= '0;
            end
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q  <= WAIT_LOCK;
                        cnt_q    <= '0;
                        pllRst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_LOCK: begin
                    if (lockS) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= RESET_PLL;
                        cnt_q     <= '0;
                        pllRst_q  <= 1'b1;
                        retries_q <= retries_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STABLE: begin
                    if (!lockS) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (!lockS) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        sysRst_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RUN: begin
                    if (!lockS) begin
                        lostLock_q <= 1'b1;
                        sysRst_q   <= 1'b1;
                        ready_q    <= 1'b0;
                        cnt_q      <= '0;
`ifdef PLL_AUTO_RELOCK_EN
                        state_q    <= RESET_PLL;
                        pllRst_q   <= 1'b1;
                        retries_q  <= retries_d;
`else
                        state_q    <= WAIT_LOCK;
`endif
                    end
                end
                default: begin
                    state_q  <= RESET_PLL;
                    cnt_q    <= '0;
                    pllRst_q <= 1'b1;
                    sysRst_q <= 1'b1;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst   = pllRst_q;
    assign sys_rst   = sysRst_q;
    assign ready     = ready_q;
    assign retries   = retries_q;
    assign lost_lock = lostLock_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: a run-length lock model checked every cycle plus literal checkpoints.
// Output bundle layout: {pll_rst, sys_rst, ready, lost_lock, retries[7:0]}.
module tb_pll_reset_ctrl;

    localparam int SYNC    = 2;
    localparam int PLL_RST = 4;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 32;
    localparam int HOLD    = 4;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lost_lock;
    logic [7:0] retries;

    int vectors     = 0;
    int miscompares = 0;

    pll_reset_ctrl #(
        .LOCK_SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES      (PLL_RST),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .HOLD_CYCLES         (HOLD)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .retries   (retries),
        .lost_lock (lost_lock)
    );

    initial forever #10 refclk = ~refclk;

    // Model state: lock history delayed by the synchroniser, pulse time left, and run lengths.
    logic       syncPipe [SYNC];
    logic       mPll, mSys, mReady, mLost;
    logic [7:0] mRetries;
    int         pulseLeft  = 0;
    int         lockRun    = 0;
    int         idle       = 0;
    bit         running    = 0;
    bit         modelValid = 0;

    function automatic logic [11:0] outs();
        return {pll_rst, sys_rst, ready, lost_lock, retries};
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic lockVal, input int cycles);
        rst    = rstVal;
        locked = lockVal;
        repeat (cycles) @(negedge refclk);
    endtask

    // Release needs STABLE+HOLD consecutive synchronised lock samples once the PLL pulse is over;
    // a timeout retry needs TIMEOUT low samples, not counting the sample that broke a lock run.
    task automatic modelStep();
        logic s;
        s = syncPipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) syncPipe[i] = syncPipe[i-1];
        syncPipe[0] = locked;
        mLost = 1'b0;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) syncPipe[i] = 1'b0;
            pulseLeft  = PLL_RST + 1;
            mPll       = 1'b1;
            mSys       = 1'b1;
            mReady     = 1'b0;
            mRetries   = 8'd0;
            lockRun    = 0;
            idle       = 0;
            running    = 0;
            modelValid = 1;
        end else if (pulseLeft > 0) begin
            pulseLeft--;
            if (pulseLeft == 0) begin
                mPll    = 1'b0;
                lockRun = 0;
                idle    = 0;
            end
        end else if (running) begin
            if (!s) begin
                mLost   = 1'b1;
                mSys    = 1'b1;
                mReady  = 1'b0;
                running = 0;
                lockRun = 0;
                idle    = 0;
`ifdef PLL_AUTO_RELOCK_EN
                pulseLeft = PLL_RST;
                mPll      = 1'b1;
                if (mRetries != 8'd255) mRetries = mRetries + 8'd1;
`endif
            end
        end else if (s) begin
            lockRun++;
            idle = 0;
            if (lockRun == STABLE + HOLD) begin
                running = 1;
                mSys    = 1'b0;
                mReady  = 1'b1;
            end
        end else if (lockRun > 0) begin
            lockRun = 0;
            idle    = 0;
        end else begin
            idle++;
            if (idle == TIMEOUT) begin
                if (mRetries != 8'd255) mRetries = mRetries + 8'd1;
                pulseLeft = PLL_RST;
                mPll      = 1'b1;
                idle      = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < SYNC; i++) syncPipe[i] = 1'b0;
        forever begin
            @(posedge refclk);
            modelStep();
        end
    end

    // Every cycle once the model has seen reset, compare all outputs against it.
    initial forever begin
        @(negedge refclk);
        if (modelValid) checkOutput("model", outs(), {mPll, mSys, mReady, mLost, mRetries});
    end

    initial begin
        $display("[TB] starting pll_reset_ctrl bench");

        // Nominal lock, then loss of lock in RUN.
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("reset values", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("first release edge", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("pll_rst before fall", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("pll_rst fall", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b1, 13);
        checkOutput("nominal before release", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("nominal release", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("loss before detect", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 1);
`ifdef PLL_AUTO_RELOCK_EN
        checkOutput("loss detect", outs(), {1'b1, 1'b1, 1'b0, 1'b1, 8'd1});
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("loss pulse ends", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
        applyStimulus(1'b0, 1'b0, 36);
        checkOutput("retry after loss", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd2});
`else
        checkOutput("loss detect", outs(), {1'b0, 1'b1, 1'b0, 1'b1, 8'd0});
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("loss pulse ends", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 36);
        checkOutput("retry after loss", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd1});
`endif

        // Lock glitch: 5 high, 1 low, then high for good.
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 13);
        checkOutput("glitch before release", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("glitch release", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});

        // One-cycle reset while in HOLD, then a full re-sequence with lock held.
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 11);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("reset in hold", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("resequence pll_rst high", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("resequence pll_rst fall", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 11);
        checkOutput("resequence before release", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("resequence release", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});

        // No lock at all: retry every 36 cycles, retries saturates at 255.
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 36);
        checkOutput("nolock before retry 1", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("nolock retry 1", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
        applyStimulus(1'b0, 1'b0, 35);
        checkOutput("nolock before retry 2", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd1});
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("nolock retry 2", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd2});
        applyStimulus(1'b0, 1'b0, 36);
        checkOutput("nolock retry 3", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd3});
        applyStimulus(1'b0, 1'b0, 36 * 300);
        checkOutput("nolock saturated", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd255});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
